dtcm_arbiter: RTL and testbench
===============================

Name: dtcm_arbiter

Overview:
- Two-requester arbiter that shares the single DTCM controller command/response channel between the core LSU (port m0) and a second data master (port m1, e.g. DMA or debug).
- Sits between the LSU's dtcm_* interface and the DTCM controller.
- Grants are round-robin and locked across stalls.
- Source IDs of outstanding commands are tracked in an in-order FIFO so each response returns to the requester that issued it.

Parameters:
- DW, 32, data width (matches XLEN); wmask width is DW/8.
- AW, 16, DTCM address width (matches DTCM_ADDR_WIDTH).
- OSTD, 2, maximum outstanding commands (source-ID FIFO depth, power of 2, ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_cmd_valid  in  1  LSU command valid
- m0_cmd_ready  out  1  LSU command accepted
- m0_cmd_read  in  1  1=read, 0=write
- m0_cmd_addr  in  AW  address
- m0_cmd_wdata  in  DW  write data
- m0_cmd_wmask  in  DW/8  byte write mask
- m0_rsp_valid  out  1  response to LSU
- m0_rsp_ready  in  1  LSU accepts response
- m0_rsp_rdata  out  DW  read data
- m1_cmd_valid / m1_cmd_ready / m1_cmd_read / m1_cmd_addr / m1_cmd_wdata / m1_cmd_wmask  same widths and meaning as m0, for master 1
- m1_rsp_valid / m1_rsp_ready / m1_rsp_rdata  same widths and meaning as m0, for master 1
- s_cmd_valid  out  1  command to DTCM controller
- s_cmd_ready  in  1  controller accepts command
- s_cmd_read  out  1  muxed read flag
- s_cmd_addr  out  AW  muxed address
- s_cmd_wdata  out  DW  muxed write data
- s_cmd_wmask  out  DW/8  muxed byte mask
- s_rsp_valid  in  1  controller response valid
- s_rsp_ready  out  1  arbiter accepts response
- s_rsp_rdata  in  DW  response data

Behaviour:
- Handshake: a transfer occurs on valid&&ready in the same cycle. Requesters hold valid and payload stable until accepted.
- Registered state:
  - rr_ptr: 1 bit, the favoured master.
  - lock: 1 bit, plus lock_id (1 bit).
  - ID FIFO: OSTD entries x 1 bit, with wr_ptr, rd_ptr and count (0..OSTD).
- Reset (async assert, released synchronously by clk edge): rr_ptr=0 (m0 favoured), lock=0, FIFO empty.
  - All outputs are 0 during reset: cmd_ready, s_cmd_valid, rsp_valid, s_rsp_ready.
  - Reset mid-transaction discards all outstanding IDs. Any later stray s_rsp_valid is ignored (s_rsp_ready=0 while FIFO empty).
- Grant selection (combinational):
  - If lock=1, grant=lock_id.
  - Else if only one master is valid, grant that master.
  - Else if both are valid, grant rr_ptr.
  - Else no grant.
- Command path is zero-latency:
  - s_cmd_valid = granted master's valid && !fifo_full.
  - s_cmd_* payload = granted master's payload (m0 payload when no grant).
  - mX_cmd_ready = (grant==X) && s_cmd_ready && !fifo_full.
- Lock: if s_cmd_valid=1 and s_cmd_ready=0, set lock=1 and lock_id=grant. Clear lock on the s_cmd handshake. The grant never changes while a command is stalled.
- On an s_cmd handshake:
  - Push the grant ID into the FIFO.
  - rr_ptr <= ~grant, so the other master is favoured next.
  - rr_ptr is unchanged when no handshake occurs.
- FIFO full (count==OSTD) blocks all new commands, even if a pop happens in the same cycle; there is no bypass.
- Response path is zero-latency and in order:
  - head = FIFO[rd_ptr].
  - m0_rsp_valid = s_rsp_valid && !empty && head==0; m1_rsp_valid likewise with head==1.
  - Both mX_rsp_rdata = s_rsp_rdata.
  - s_rsp_ready = !empty && (head ? m1_rsp_ready : m0_rsp_ready).
  - Pop on an s_rsp handshake.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo OSTD.
- No combinational path from any rsp input to any cmd output.

Test Plan:
1. Single master: m0 issues read addr 0x0010, s_cmd_ready=1, rsp rdata 0xDEADBEEF one cycle later -> s_cmd_addr=0x0010 same cycle; m0_rsp_valid with 0xDEADBEEF; m1_rsp_valid stays 0.
2. Contention after reset: m0 and m1 both valid every cycle, s_cmd_ready=1, responses returned promptly -> grants alternate m0,m1,m0,m1; each response is routed to its issuer.
3. Stall lock: both valid, m0 granted, s_cmd_ready=0 for 3 cycles -> s_cmd payload stays m0 for all 3 cycles; m1_cmd_ready=0; after acceptance the next grant is m1.
4. FIFO full (OSTD=2): two m1 writes accepted, no responses -> third command sees s_cmd_valid=0 and m0/m1_cmd_ready=0. One response pops -> the next command is accepted the following cycle.
5. Response backpressure: head=m0, m0_rsp_ready=0 -> s_rsp_ready=0, FIFO not popped. Raise m0_rsp_ready -> pop; the following response goes to m1 per FIFO order.
6. Reset mid-operation: two commands outstanding, assert rst asynchronously mid-cycle -> outputs drop immediately; after release count=0 and an s_rsp_valid pulse is not acknowledged (s_rsp_ready=0).

Source files
------------

// File: rtl/dtcm_arbiter.sv
// Two-master round-robin arbiter in front of the DTCM controller command/response channel.
// Grants lock across command stalls; an in-order source-ID FIFO steers responses back to their issuer.
module dtcm_arbiter #(
  parameter int DW   = 32,
  parameter int AW   = 16,
  parameter int OSTD = 2
) (
  input  logic            clk,
  input  logic            rst,
  // master 0 (LSU)
  input  logic            m0_cmd_valid,
  output logic            m0_cmd_ready,
  input  logic            m0_cmd_read,
  input  logic [AW-1:0]   m0_cmd_addr,
  input  logic [DW-1:0]   m0_cmd_wdata,
  input  logic [DW/8-1:0] m0_cmd_wmask,
  output logic            m0_rsp_valid,
  input  logic            m0_rsp_ready,
  output logic [DW-1:0]   m0_rsp_rdata,
  // master 1 (DMA / debug)
  input  logic            m1_cmd_valid,
  output logic            m1_cmd_ready,
  input  logic            m1_cmd_read,
  input  logic [AW-1:0]   m1_cmd_addr,
  input  logic [DW-1:0]   m1_cmd_wdata,
  input  logic [DW/8-1:0] m1_cmd_wmask,
  output logic            m1_rsp_valid,
  input  logic            m1_rsp_ready,
  output logic [DW-1:0]   m1_rsp_rdata,
  // DTCM controller side
  output logic            s_cmd_valid,
  input  logic            s_cmd_ready,
  output logic            s_cmd_read,
  output logic [AW-1:0]   s_cmd_addr,
  output logic [DW-1:0]   s_cmd_wdata,
  output logic [DW/8-1:0] s_cmd_wmask,
  input  logic            s_rsp_valid,
  output logic            s_rsp_ready,
  input  logic [DW-1:0]   s_rsp_rdata
);

  // Handshake: a transfer happens on valid && ready in the same cycle; the
  // source holds valid and payload stable until the transfer happens.

  localparam int PW = (OSTD > 1) ? $clog2(OSTD) : 1;
  localparam int CW = $clog2(OSTD + 1);

  logic            r_rr_ptr;
  logic            r_lock;
  logic            r_lock_id;
  logic [OSTD-1:0] r_id_mem;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic w_grant_valid;
  logic w_grant;
  logic w_sel_valid;
  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_cmd_hs;
  logic w_rsp_hs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (OSTD == 1) return '0;
    return (p == PW'(OSTD - 1)) ? '0 : p + 1'b1;
  endfunction

  // A locked grant wins over everything so a stalled command is never swapped out.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = 1'b0;
    if (r_lock) begin
      w_grant_valid = 1'b1;
      w_grant       = r_lock_id;
    end else if (m0_cmd_valid && m1_cmd_valid) begin
      w_grant_valid = 1'b1;
      w_grant       = r_rr_ptr;
    end else if (m0_cmd_valid) begin
      w_grant_valid = 1'b1;
      w_grant       = 1'b0;
    end else if (m1_cmd_valid) begin
      w_grant_valid = 1'b1;
      w_grant       = 1'b1;
    end
  end

  assign w_full      = (r_count == CW'(OSTD));
  assign w_empty     = (r_count == '0);
  assign w_sel_valid = w_grant ? m1_cmd_valid : m0_cmd_valid;

  // Outputs are forced low while rst is high, including the async-assert window.
  assign s_cmd_valid  = !rst && w_grant_valid && w_sel_valid && !w_full;
  assign s_cmd_read   = w_grant ? m1_cmd_read  : m0_cmd_read;
  assign s_cmd_addr   = w_grant ? m1_cmd_addr  : m0_cmd_addr;
  assign s_cmd_wdata  = w_grant ? m1_cmd_wdata : m0_cmd_wdata;
  assign s_cmd_wmask  = w_grant ? m1_cmd_wmask : m0_cmd_wmask;
  assign m0_cmd_ready = !rst && w_grant_valid && !w_grant && s_cmd_ready && !w_full;
  assign m1_cmd_ready = !rst && w_grant_valid &&  w_grant && s_cmd_ready && !w_full;

  assign w_head       = r_id_mem[r_rd_ptr];
  assign m0_rsp_valid = !rst && s_rsp_valid && !w_empty && !w_head;
  assign m1_rsp_valid = !rst && s_rsp_valid && !w_empty &&  w_head;
  assign m0_rsp_rdata = s_rsp_rdata;
  assign m1_rsp_rdata = s_rsp_rdata;
  assign s_rsp_ready  = !rst && !w_empty && (w_head ? m1_rsp_ready : m0_rsp_ready);

  assign w_cmd_hs = s_cmd_valid && s_cmd_ready;
  assign w_rsp_hs = s_rsp_valid && s_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= 1'b0;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
      r_id_mem  <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_lock             <= 1'b0;
        r_rr_ptr           <= ~w_grant;
        r_id_mem[r_wr_ptr] <= w_grant;
        r_wr_ptr           <= ptr_inc(r_wr_ptr);
      end else if (s_cmd_valid && !s_cmd_ready) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_grant;
      end
      if (w_rsp_hs) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_cmd_hs, w_rsp_hs})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Bench for dtcm_arbiter: directed corner cases plus randomized traffic
// checked against a queue-based model of arbitration and response routing.
module tb_dtcm_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int OSTD = 2;
  localparam int MW   = DW / 8;

  logic          clk;
  logic          rst;
  logic          m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
  logic [AW-1:0] m0_cmd_addr;
  logic [DW-1:0] m0_cmd_wdata;
  logic [MW-1:0] m0_cmd_wmask;
  logic          m0_rsp_valid, m0_rsp_ready;
  logic [DW-1:0] m0_rsp_rdata;
  logic          m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
  logic [AW-1:0] m1_cmd_addr;
  logic [DW-1:0] m1_cmd_wdata;
  logic [MW-1:0] m1_cmd_wmask;
  logic          m1_rsp_valid, m1_rsp_ready;
  logic [DW-1:0] m1_rsp_rdata;
  logic          s_cmd_valid, s_cmd_ready, s_cmd_read;
  logic [AW-1:0] s_cmd_addr;
  logic [DW-1:0] s_cmd_wdata;
  logic [MW-1:0] s_cmd_wmask;
  logic          s_rsp_valid, s_rsp_ready;
  logic [DW-1:0] s_rsp_rdata;

  dtcm_arbiter #(.DW(DW), .AW(AW), .OSTD(OSTD)) dut (
    .clk(clk), .rst(rst),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_read(s_cmd_read),
    .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [0:0] exp_q[$];   // issuer of each outstanding command, oldest first
  int         favour;     // master preferred on a tie
  int         stalled;    // master whose command is waiting on s_cmd_ready, -1 if none

  // driver state for the randomized phases
  logic          mv[2];
  logic          mrd[2];
  logic [AW-1:0] maddr[2];
  logic [DW-1:0] mwd[2];
  logic [MW-1:0] mwm[2];
  logic          acc[2];
  logic          srv, rsp_acc;
  logic [DW-1:0] srd;
  int p_req, p_sready, p_rsp, p_rr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    favour  = 0;
    stalled = -1;
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; mrd[m] = 1'b0; maddr[m] = '0; mwd[m] = '0; mwm[m] = '0; acc[m] = 1'b0;
    end
    srv = 1'b0; rsp_acc = 1'b0; srd = '0;
  endtask

  task automatic idle_inputs();
    m0_cmd_valid = 0; m0_cmd_read = 0; m0_cmd_addr = '0; m0_cmd_wdata = '0; m0_cmd_wmask = '0;
    m1_cmd_valid = 0; m1_cmd_read = 0; m1_cmd_addr = '0; m1_cmd_wdata = '0; m1_cmd_wmask = '0;
    m0_rsp_ready = 0; m1_rsp_ready = 0; s_cmd_ready = 0; s_rsp_valid = 0; s_rsp_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_m(input int m, input logic v, input logic rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    if (m == 0) begin
      m0_cmd_valid = v; m0_cmd_read = rd; m0_cmd_addr = a; m0_cmd_wdata = wd; m0_cmd_wmask = wm;
    end else begin
      m1_cmd_valid = v; m1_cmd_read = rd; m1_cmd_addr = a; m1_cmd_wdata = wd; m1_cmd_wmask = wm;
    end
  endtask

  // One randomized cycle: drive at negedge, check 1 ns later, update model after posedge.
  task automatic step();
    int  g;
    bit  gv, full, cmd_hs, rsp_hs, nonempty, head;
    logic exp_sv, exp_srr;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      if (acc[m]) mv[m] = 1'b0;
      if (!mv[m] && $urandom_range(0, 99) < p_req) begin
        mv[m] = 1'b1; mrd[m] = 1'($urandom_range(0, 1)); maddr[m] = AW'($urandom);
        mwd[m] = $urandom; mwm[m] = MW'($urandom_range(0, 15));
      end
      drive_m(m, mv[m], mrd[m], maddr[m], mwd[m], mwm[m]);
    end
    if (rsp_acc) srv = 1'b0;
    if (!srv) begin
      if (exp_q.size() > 0) srv = ($urandom_range(0, 99) < p_rsp);
      else                  srv = ($urandom_range(0, 99) < 5);
      srd = $urandom;
    end
    s_rsp_valid  = srv;
    s_rsp_rdata  = srd;
    s_cmd_ready  = ($urandom_range(0, 99) < p_sready);
    m0_rsp_ready = ($urandom_range(0, 99) < p_rr);
    m1_rsp_ready = ($urandom_range(0, 99) < p_rr);
    #1;
    // reference: who should own the channel this cycle
    if (stalled >= 0)          begin gv = 1; g = stalled; end
    else if (mv[0] && mv[1])   begin gv = 1; g = favour;  end
    else if (mv[0])            begin gv = 1; g = 0;       end
    else if (mv[1])            begin gv = 1; g = 1;       end
    else                       begin gv = 0; g = 0;       end
    full     = (exp_q.size() == OSTD);
    exp_sv   = gv && mv[g] && !full;
    nonempty = (exp_q.size() > 0);
    head     = nonempty ? exp_q[0] : 1'b0;
    exp_srr  = nonempty && (head ? m1_rsp_ready : m0_rsp_ready);
    chk("s_cmd_valid", s_cmd_valid, exp_sv);
    chk("s_cmd_payload", {s_cmd_read, s_cmd_addr, s_cmd_wdata, s_cmd_wmask},
        {mrd[g], maddr[g], mwd[g], mwm[g]});
    chk("m0_cmd_ready", m0_cmd_ready, gv && g == 0 && s_cmd_ready && !full);
    chk("m1_cmd_ready", m1_cmd_ready, gv && g == 1 && s_cmd_ready && !full);
    chk("m0_rsp_valid", m0_rsp_valid, srv && nonempty && !head);
    chk("m1_rsp_valid", m1_rsp_valid, srv && nonempty && head);
    chk("s_rsp_ready", s_rsp_ready, exp_srr);
    chk("m0_rsp_rdata", m0_rsp_rdata, srd);
    chk("m1_rsp_rdata", m1_rsp_rdata, srd);
    cmd_hs  = exp_sv && s_cmd_ready;
    rsp_hs  = srv && exp_srr;
    acc[0]  = cmd_hs && g == 0;
    acc[1]  = cmd_hs && g == 1;
    rsp_acc = rsp_hs;
    @(posedge clk);
    if (rsp_hs) void'(exp_q.pop_front());
    if (cmd_hs) begin
      exp_q.push_back(1'(g));
      favour  = 1 - g;
      stalled = -1;
    end else if (exp_sv) begin
      stalled = g;
    end
  endtask

  task automatic run_phase(input int n, input int req, input int sr, input int rsp, input int rr);
    p_req = req; p_sready = sr; p_rsp = rsp; p_rr = rr;
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    // reset state: requests present but nothing may be granted or acknowledged
    drive_m(0, 1, 1, 16'h0010, '0, '0);
    drive_m(1, 1, 0, 16'h0020, '0, '0);
    s_cmd_ready = 1; s_rsp_valid = 1; m0_rsp_ready = 1; m1_rsp_ready = 1;
    #1;
    chk("rst_s_cmd_valid", s_cmd_valid, 0);
    chk("rst_m0_cmd_ready", m0_cmd_ready, 0);
    chk("rst_m1_cmd_ready", m1_cmd_ready, 0);
    chk("rst_s_rsp_ready", s_rsp_ready, 0);
    chk("rst_m0_rsp_valid", m0_rsp_valid, 0);
    do_reset();

    // single-master read, response one cycle later
    drive_m(0, 1, 1, 16'h0010, '0, '0);
    s_cmd_ready = 1;
    #1;
    chk("t1_s_cmd_valid", s_cmd_valid, 1);
    chk("t1_s_cmd_addr", s_cmd_addr, 16'h0010);
    chk("t1_m0_cmd_ready", m0_cmd_ready, 1);
    @(negedge clk);
    drive_m(0, 0, 0, '0, '0, '0);
    s_rsp_valid = 1; s_rsp_rdata = 32'hDEADBEEF; m0_rsp_ready = 1; m1_rsp_ready = 1;
    #1;
    chk("t1_m0_rsp_valid", m0_rsp_valid, 1);
    chk("t1_m0_rsp_rdata", m0_rsp_rdata, 32'hDEADBEEF);
    chk("t1_m1_rsp_valid", m1_rsp_valid, 0);
    chk("t1_s_rsp_ready", s_rsp_ready, 1);
    @(negedge clk);
    s_rsp_valid = 0;
    #1;
    chk("t1_drained", s_rsp_ready, 0);
    do_reset();

    // randomized phases: contention, stalls, FIFO full, response backpressure, mixed
    run_phase(200, 100, 100, 100, 100);
    run_phase(300, 100, 30, 80, 90);
    run_phase(300, 80, 90, 10, 90);
    run_phase(300, 70, 80, 80, 40);
    run_phase(900, 50, 60, 50, 60);

    // reset with two commands outstanding
    do_reset();
    drive_m(0, 1, 0, 16'h0100, 32'h1111_1111, 4'hF);
    drive_m(1, 1, 0, 16'h0200, 32'h2222_2222, 4'hF);
    s_cmd_ready = 1;
    repeat (2) @(negedge clk);
    s_rsp_valid = 1; s_rsp_rdata = 32'h5A5A_5A5A; m0_rsp_ready = 1; m1_rsp_ready = 1;
    #1;
    chk("t6_full_s_cmd_valid", s_cmd_valid, 0);
    chk("t6_head_m0", m0_rsp_valid, 1);
    chk("t6_s_rsp_ready", s_rsp_ready, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_s_rsp_ready", s_rsp_ready, 0);
    chk("t6_async_m0_rsp_valid", m0_rsp_valid, 0);
    chk("t6_async_m0_cmd_ready", m0_cmd_ready, 0);
    chk("t6_async_s_cmd_valid", s_cmd_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    drive_m(0, 0, 0, '0, '0, '0);
    drive_m(1, 0, 0, '0, '0, '0);
    #1;
    chk("t6_stray_s_rsp_ready", s_rsp_ready, 0);
    chk("t6_stray_m0_rsp_valid", m0_rsp_valid, 0);
    chk("t6_stray_m1_rsp_valid", m1_rsp_valid, 0);
    @(negedge clk);
    // favour restored to m0 and FIFO empty: a tie must go to m0 and be accepted
    drive_m(0, 1, 1, 16'h0300, '0, '0);
    drive_m(1, 1, 1, 16'h0400, '0, '0);
    s_rsp_valid = 0;
    #1;
    chk("t6_post_addr", s_cmd_addr, 16'h0300);
    chk("t6_post_m0_ready", m0_cmd_ready, 1);
    chk("t6_post_m1_ready", m1_cmd_ready, 0);
    @(negedge clk);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
